// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, start/busy/done handshake.
// Define BIN2BCD_SIGNED_EN to treat iBin as two's complement and report the sign on oNeg.
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iStart,
  input  logic [BIN_W-1:0]      iBin,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [4*DIGITS-1:0]   oBcd,
  output logic                  oNeg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // True when DIGITS decimal digits can represent every BIN_W-bit value.
  function automatic bit digitsCoverRange();
    longint unsigned cap;
    cap = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cap <= (64'd1 << BIN_W)) cap = cap * 10;
    end
    return cap > (64'd1 << BIN_W);
  endfunction

  if (BIN_W < 4 || BIN_W > 32) begin : gBadWidth
    $error("bin2bcd_seq: BIN_W=%0d outside legal range 4..32", BIN_W);
  end
  if (!digitsCoverRange()) begin : gBadDigits
    $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, nextState;
  logic [BIN_W-1:0]   shiftReg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adjScratch;
  logic [BCD_W-1:0]   nextScratch;
  logic [CNT_W-1:0]   count;
  logic [BIN_W-1:0]   loadMag;
  logic               lastStep;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= nextState;
  end

  // NOTE: every output of this block is given a default first so no path
  // through the case leaves a variable unassigned (which would infer a latch).
  always_comb begin
    nextState = state;
    oBusy     = 1'b1;
    oDone     = 1'b0;
    lastStep  = 1'b0;
    case (state)
      IDLE: begin
        oBusy = 1'b0;
        if (iStart) nextState = SHIFT;
      end
      SHIFT: begin
        if (count == CNT_W'(1)) begin
          lastStep  = 1'b1;
          nextState = DONE;
        end
      end
      DONE: begin
        oDone     = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Add-3 correction on each digit >= 5, then shift the next binary bit in.
  always_comb begin
    adjScratch = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adjScratch[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
    nextScratch = {adjScratch[BCD_W-2:0], shiftReg[BIN_W-1]};
  end

`ifdef BIN2BCD_SIGNED_EN
  logic loadNeg;
  logic negFlag;
  logic negResult;

  assign loadNeg = iBin[BIN_W-1];
  // Two's-complement negate; the most negative value maps to 2^(BIN_W-1) unsigned.
  assign loadMag = loadNeg ? (~iBin + BIN_W'(1)) : iBin;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      negFlag   <= 1'b0;
      negResult <= 1'b0;
    end else begin
      if (state == IDLE && iStart) negFlag   <= loadNeg;
      if (lastStep)                negResult <= negFlag;
    end
  end

  assign oNeg = negResult;
`else
  assign loadMag = iBin;
  assign oNeg    = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      shiftReg <= '0;
      scratch  <= '0;
      count    <= '0;
      oBcd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            shiftReg <= loadMag;
            scratch  <= '0;
            count    <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          scratch  <= nextScratch;
          shiftReg <= shiftReg << 1;
          count    <= count - CNT_W'(1);
          // oBcd only updates on the final step so displays never see partial digits.
          if (lastStep) oBcd <= nextScratch;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: scoreboard of expected results, one task per scenario.
// Expectations follow BIN2BCD_SIGNED_EN when the bench is built with it defined.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;

  typedef struct packed {
    logic        neg;
    logic [19:0] bcd;
  } result_t;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iStart = 1'b0;
  logic [15:0] iBin = '0;
  logic        oBusy;
  logic        oDone;
  logic [19:0] oBcd;
  logic        oNeg;

  result_t expQ[$];
  int checks = 0;
  int errors = 0;
  int doneCount = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iStart (iStart),
    .iBin   (iBin),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oBcd   (oBcd),
    .oNeg   (oNeg)
  );

  always #5 iClk = ~iClk;

  // Counts DONE cycles, sampled at the edge that ends each cycle.
  always @(posedge iClk) if (oDone === 1'b1) doneCount++;

  // Reference: decimal digits by repeated division.
  function automatic result_t model(input logic [15:0] b);
    result_t     r;
    int unsigned m;
    r.neg = 1'b0;
    m = b;
`ifdef BIN2BCD_SIGNED_EN
    if (b[15]) begin
      r.neg = 1'b1;
      m = 32'd65536 - 32'(b);
    end
`endif
    for (int i = 0; i < DIGITS; i++) begin
      r.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Called at the first negedge after acceptance; returns cycles to oDone or -1.
  task automatic waitDone(output int cyc);
    cyc = 1;
    while (oDone !== 1'b1 && cyc < 40) begin
      @(negedge iClk);
      cyc++;
    end
    if (oDone !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0;
    repeat (2) @(negedge iClk);
    checks++;
    if ({oBusy, oDone, oNeg, oBcd} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b neg=%b bcd=%h, want all 0", oBusy, oDone, oNeg, oBcd);
    end
    iRst_n = 1'b1;
    @(negedge iClk);
    checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", oBusy, oDone);
    end
  endtask

  task automatic test_zero();
    int      cyc;
    result_t exp, got;
    iStart = 1'b1;
    iBin   = 16'd0;
    expQ.push_back(model(16'd0));
    @(negedge iClk);
    iStart = 1'b0;
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL zero_busy: got %b, want 1", oBusy);
    end
    waitDone(cyc);
    checks++;
    if (cyc != 17) begin
      errors++;
      $display("FAIL zero_latency: got %0d cycles, want 17", cyc);
    end
    if (cyc > 0) begin
      got = {oNeg, oBcd};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp || got !== 21'h0) begin
        errors++;
        $display("FAIL zero_result: got neg=%b bcd=%h, want neg=%b bcd=%h", got.neg, got.bcd, exp.neg, exp.bcd);
      end
    end else expQ.delete();
    @(negedge iClk);
    checks++;
    if (oDone !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%b busy=%b after DONE, want 0 0", oDone, oBusy);
    end
  endtask

  task automatic test_values();
    logic [15:0] vals[3];
    logic [19:0] prev;
    result_t     exp, got;
    int          cyc;
    bit          holdOk;
    vals = '{16'd65535, 16'd1234, 16'd9};
    prev = 20'h00000;
    foreach (vals[i]) begin
      iStart = 1'b1;
      iBin   = vals[i];
      expQ.push_back(model(vals[i]));
      @(negedge iClk);
      iStart = 1'b0;
      iBin   = 16'hA5A5;
      holdOk = 1'b1;
      cyc = 1;
      while (oDone !== 1'b1 && cyc < 40) begin
        if (oBcd !== prev) holdOk = 1'b0;
        @(negedge iClk);
        cyc++;
      end
      checks++;
      if (!holdOk) begin
        errors++;
        $display("FAIL hold_%0d: oBcd changed during SHIFT, want held %h", i, prev);
      end
      checks++;
      if (oDone !== 1'b1) begin
        errors++;
        $display("FAIL value_%0d_timeout: got no oDone, want oDone", i);
        expQ.delete();
      end else begin
        got = {oNeg, oBcd};
        exp = expQ.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL value_%0d: got neg=%b bcd=%h, want neg=%b bcd=%h", i, got.neg, got.bcd, exp.neg, exp.bcd);
        end
        prev = exp.bcd;
      end
      @(negedge iClk);
    end
  endtask

  task automatic test_ignored_start();
    int      cyc, d0;
    result_t exp, got;
    d0 = doneCount;
    iStart = 1'b1;
    iBin   = 16'd100;
    expQ.push_back(model(16'd100));
    @(negedge iClk);
    for (cyc = 1; cyc < 17; cyc++) begin
      iStart = (cyc == 5 || cyc == 16);
      iBin   = 16'd7;
      @(negedge iClk);
    end
    iStart = 1'b0;
    checks++;
    if (oDone !== 1'b1) begin
      errors++;
      $display("FAIL ignored_done: got oDone=%b at cycle 17, want 1", oDone);
      expQ.delete();
    end else begin
      got = {oNeg, oBcd};
      exp = expQ.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL ignored_result: got bcd=%h, want %h", got.bcd, exp.bcd);
      end
    end
    @(negedge iClk);
    checks++;
    if (doneCount - d0 != 1) begin
      errors++;
      $display("FAIL ignored_single_done: got %0d pulses, want 1", doneCount - d0);
    end
    iStart = 1'b1;
    iBin   = 16'd7;
    expQ.push_back(model(16'd7));
    @(negedge iClk);
    iStart = 1'b0;
    waitDone(cyc);
    checks++;
    if (cyc != 17) begin
      errors++;
      $display("FAIL first_idle_accept: got latency %0d, want 17", cyc);
      expQ.delete();
    end else begin
      got = {oNeg, oBcd};
      exp = expQ.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL first_idle_result: got bcd=%h, want %h", got.bcd, exp.bcd);
      end
    end
    @(negedge iClk);
  endtask

  task automatic test_back_to_back();
    int      doneAt[$];
    result_t exp, got;
    iStart = 1'b1;
    iBin   = 16'd0;
    for (int v = 0; v < 3; v++) expQ.push_back(model(16'(v)));
    for (int cyc = 1; cyc <= 56; cyc++) begin
      @(negedge iClk);
      if (cyc == 1)  iBin = 16'd1;
      if (cyc == 19) iBin = 16'd2;
      if (oDone === 1'b1) begin
        doneAt.push_back(cyc);
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_done: got oDone at cycle %0d, want none", cyc);
        end else begin
          got = {oNeg, oBcd};
          exp = expQ.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL b2b_result: got bcd=%h, want %h", got.bcd, exp.bcd);
          end
        end
      end
      if (cyc == 53) iStart = 1'b0;
    end
    checks++;
    if (doneAt.size() != 3 || doneAt[0] != 17 || doneAt[1] != 35 || doneAt[2] != 53) begin
      errors++;
      $display("FAIL b2b_timing: got %0d pulses, first at %0d, want 3 at 17/35/53",
               doneAt.size(), (doneAt.size() > 0) ? doneAt[0] : -1);
    end
    expQ.delete();
  endtask

  task automatic test_reset_mid();
    int      cyc, d0;
    result_t exp, got;
    iStart = 1'b1;
    iBin   = 16'd4321;
    expQ.push_back(model(16'd4321));
    @(negedge iClk);
    iStart = 1'b0;
    repeat (7) @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    checks++;
    if ({oBusy, oDone, oNeg, oBcd} !== 23'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b neg=%b bcd=%h, want all 0", oBusy, oDone, oNeg, oBcd);
    end
    expQ.delete();
    d0 = doneCount;
    @(negedge iClk);
    iRst_n = 1'b1;
    repeat (25) @(negedge iClk);
    checks++;
    if (doneCount != d0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_discard: got %0d pulses busy=%b, want 0 pulses busy=0", doneCount - d0, oBusy);
    end
    iStart = 1'b1;
    iBin   = 16'd4321;
    expQ.push_back(model(16'd4321));
    @(negedge iClk);
    iStart = 1'b0;
    waitDone(cyc);
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL reset_mid_restart_timeout: got no oDone, want oDone");
      expQ.delete();
    end else begin
      got = {oNeg, oBcd};
      exp = expQ.pop_front();
      if (got !== exp || got.bcd !== 20'h04321) begin
        errors++;
        $display("FAIL reset_mid_restart: got bcd=%h, want %h", got.bcd, exp.bcd);
      end
    end
    @(negedge iClk);
  endtask

  task automatic test_signed();
    logic [15:0] vals[$];
    result_t     exp, got;
    int          cyc;
`ifdef BIN2BCD_SIGNED_EN
    vals = '{16'hFFFF, 16'h8000, 16'h7FFF};
`else
    vals = '{16'h8000};
`endif
    foreach (vals[i]) begin
      iStart = 1'b1;
      iBin   = vals[i];
      expQ.push_back(model(vals[i]));
      @(negedge iClk);
      iStart = 1'b0;
      waitDone(cyc);
      checks++;
      if (cyc < 0) begin
        errors++;
        $display("FAIL signed_%h_timeout: got no oDone, want oDone", vals[i]);
        expQ.delete();
      end else begin
        got = {oNeg, oBcd};
        exp = expQ.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL signed_%h: got neg=%b bcd=%h, want neg=%b bcd=%h", vals[i], got.neg, got.bcd, exp.neg, exp.bcd);
        end
      end
      @(negedge iClk);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_signed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
